// File: rtl/pipe_pkg.sv
// Shared types and widths for the elastic pipeline stage and its statistics counters.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL1 = 2'd1,
        FULL2 = 2'd2
    } pipe_state_t;

    localparam int OCC_W  = 2;
    localparam int STAT_W = 16;

    function automatic logic [OCC_W-1:0] occ_of(input pipe_state_t s);
        case (s)
            FULL1:   occ_of = OCC_W'(1);
            FULL2:   occ_of = OCC_W'(2);
            default: occ_of = OCC_W'(0);
        endcase
    endfunction

endpackage

// File: rtl/pipe_stage_stats.sv
// Saturating stall / bubble cycle counters observing the output handshake of a pipeline stage.
// Latency: counts visible the cycle after the observed condition. No backpressure; observe-only.
// Cleared only by rst.
module pipe_stage_stats
    import pipe_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              out_valid,
    input  logic              out_ready,
    output logic [STAT_W-1:0] stall_cnt,
    output logic [STAT_W-1:0] bubble_cnt
);

    logic stall_hit;
    logic bubble_hit;

    assign stall_hit  = out_valid && !out_ready;
    assign bubble_hit = !out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (stall_hit && (stall_cnt != {STAT_W{1'b1}}))
                stall_cnt <= stall_cnt + STAT_W'(1);
            if (bubble_hit && (bubble_cnt != {STAT_W{1'b1}}))
                bubble_cnt <= bubble_cnt + STAT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic valid/ready pipeline register with optional one-entry skid; PIPE_STAGE_STATS_EN adds stall/bubble counters.
// Latency: a beat accepted in cycle N is presented on out_data/out_valid in cycle N+1.
// Backpressure: SKID_EN=1 gives a flopped in_ready (low only when both entries held); SKID_EN=0 passes out_ready through.
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int               DATA_W    = 48,
    parameter logic [DATA_W-1:0] RESET_VAL = '0,
    parameter bit               SKID_EN   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
`ifdef PIPE_STAGE_STATS_EN
    output logic [STAT_W-1:0] stall_cnt,
    output logic [STAT_W-1:0] bubble_cnt,
`endif
    output logic [OCC_W-1:0]  occupancy
);

    pipe_state_t       state;
    logic [DATA_W-1:0] main_data;
    logic [DATA_W-1:0] skid_data;
    logic              out_valid_q;
    logic              in_ready_q;
    logic [OCC_W-1:0]  occ_q;
    logic              accept;
    logic              emit;

    // Without the skid entry, a full stage can only take a beat when the held one leaves this cycle.
    assign in_ready  = SKID_EN ? in_ready_q : (!out_valid_q || out_ready);
    assign out_valid = out_valid_q;
    assign out_data  = main_data;
    assign occupancy = occ_q;

    assign accept = in_valid && in_ready;
    assign emit   = out_valid_q && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= EMPTY;
            main_data   <= RESET_VAL;
            skid_data   <= RESET_VAL;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            occ_q       <= occ_of(EMPTY);
        end else if (flush) begin
            // Squash everything, including a beat accepted this very cycle.
            state       <= EMPTY;
            main_data   <= RESET_VAL;
            skid_data   <= RESET_VAL;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            occ_q       <= occ_of(EMPTY);
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state       <= FULL1;
                        main_data   <= in_data;
                        out_valid_q <= 1'b1;
                        in_ready_q  <= 1'b1;
                        occ_q       <= occ_of(FULL1);
                    end
                end
                FULL1: begin
                    if (accept && !emit && SKID_EN) begin
                        state      <= FULL2;
                        skid_data  <= in_data;
                        in_ready_q <= 1'b0;
                        occ_q      <= occ_of(FULL2);
                    end else if (emit && !accept) begin
                        state       <= EMPTY;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        occ_q       <= occ_of(EMPTY);
                    end else if (accept && emit) begin
                        main_data <= in_data;
                    end
                end
                FULL2: begin
                    if (emit) begin
                        state      <= FULL1;
                        main_data  <= skid_data;
                        in_ready_q <= 1'b1;
                        occ_q      <= occ_of(FULL1);
                    end
                end
                default: begin
                    state       <= EMPTY;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    occ_q       <= occ_of(EMPTY);
                end
            endcase
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    pipe_stage_stats u_stats (
        .clk        (clk),
        .rst        (rst),
        .out_valid  (out_valid_q),
        .out_ready  (out_ready),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
    );
`endif

endmodule
